// File: rtl/bus_drive_sequencer_if.sv
// Handshake and bus-strobe bundle between the control sequencer and the datapath.
// master = sequencer side, slave = datapath side.
interface bus_drive_sequencer_if;
  logic        run;
  logic [31:0] ir;
  logic        mem_ready;

  // bus-drive strobes (at most one high per cycle)
  logic        PCout, MDRout, Zlowout, Zhighout, HIout, LOout, Yout, InPortout, Cout;
  logic [15:0] RoutSignals;

  // load strobes
  logic        MARin, PCin, MDRin, IRin, Yin, Zin, IncPC, Read;
  logic [15:0] Rin;

  logic [4:0]  alu_op;
  logic        done;
  logic        halted;

  modport master (
    input  run, ir, mem_ready,
    output PCout, MDRout, Zlowout, Zhighout, HIout, LOout, Yout, InPortout, Cout, RoutSignals,
    output MARin, PCin, MDRin, IRin, Yin, Zin, IncPC, Read, Rin,
    output alu_op, done, halted
  );

  modport slave (
    output run, ir, mem_ready,
    input  PCout, MDRout, Zlowout, Zhighout, HIout, LOout, Yout, InPortout, Cout, RoutSignals,
    input  MARin, PCin, MDRin, IRin, Yin, Zin, IncPC, Read, Rin,
    input  alu_op, done, halted
  );
endinterface

// File: rtl/bus_drive_sequencer.sv
// Moore control sequencer: fetch (T0-T2) then opcode-dependent execute (T3-T5).
// Every output is decoded from the state register and ir only, so run and
// mem_ready never reach an output combinationally.
module bus_drive_sequencer (
  input  logic                  clock,
  input  logic                  reset_n,
  bus_drive_sequencer_if.master bus
);

  typedef enum logic [2:0] {IDLE, T0, T1, T2, T3, T4, T5, HALT} state_t;

  typedef struct packed {
    logic pc, mdr, zlow, zhigh, hi, lo, y, inport, c;
  } drive_t;

  typedef struct packed {
    logic mar, pc, mdr, ir, y, z, inc_pc, read;
  } load_t;

  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11010;

  state_t      state, state_nx;
  logic        t1_first;     // high only during the first cycle of T1
  logic [4:0]  opcode;
  logic [3:0]  ra, rb, rc;
  logic        is_rtype;
  logic        ir_unused;

  drive_t      drv;
  load_t       ld;
  logic [15:0] rout, rin;
  logic [4:0]  alu;
  logic        done_o, halted_o;

  assign opcode    = bus.ir[31:27];
  assign ra        = bus.ir[26:23];
  assign rb        = bus.ir[22:19];
  assign rc        = bus.ir[18:15];
  assign is_rtype  = (opcode[4:2] == 3'b000);   // add/sub/and/or
  assign ir_unused = ^bus.ir[14:0];

  // State register; reset drops straight to IDLE regardless of clock.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      t1_first <= 1'b0;
    end else begin
      state    <= state_nx;
      t1_first <= (state == T0);   // T0 always moves to T1
    end
  end

  // Next-state: run only matters in IDLE and on the done step, never mid-instruction.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (bus.run) state_nx = T0;
      T0:   state_nx = T1;
      T1:   if (bus.mem_ready) state_nx = T2;
      T2:   state_nx = T3;
      T3: begin
        if (is_rtype)              state_nx = T4;
        else if (opcode == OP_HALT) state_nx = HALT;
        else                       state_nx = bus.run ? T0 : IDLE;
      end
      T4:   state_nx = T5;
      T5:   state_nx = bus.run ? T0 : IDLE;
      HALT: state_nx = HALT;
      default: state_nx = IDLE;
    endcase
  end

  // Output decode from state and ir.
  always_comb begin
    drv      = '0;
    ld       = '0;
    rout     = '0;
    rin      = '0;
    alu      = '0;
    done_o   = 1'b0;
    halted_o = 1'b0;
    case (state)
      T0: begin
        drv.pc    = 1'b1;
        ld.mar    = 1'b1;
        ld.inc_pc = 1'b1;
        ld.z      = 1'b1;
        alu       = 5'b00000;
      end
      T1: begin
        // Read/MDRin held through the memory wait; PC reload only once.
        drv.zlow = 1'b1;
        ld.pc    = t1_first;
        ld.read  = 1'b1;
        ld.mdr   = 1'b1;
      end
      T2: begin
        drv.mdr = 1'b1;
        ld.ir   = 1'b1;
      end
      T3: begin
        if (is_rtype) begin
          rout = 16'b1 << rb;
          ld.y = 1'b1;
        end else if (opcode == OP_MFHI) begin
          drv.hi = 1'b1;
          rin    = 16'b1 << ra;
          done_o = 1'b1;
        end else if (opcode == OP_MFLO) begin
          drv.lo = 1'b1;
          rin    = 16'b1 << ra;
          done_o = 1'b1;
        end else begin
          done_o = 1'b1;   // halt and unknown opcodes
        end
      end
      T4: begin
        rout = 16'b1 << rc;
        ld.z = 1'b1;
        alu  = opcode;
      end
      T5: begin
        drv.zlow = 1'b1;
        rin      = 16'b1 << ra;
        done_o   = 1'b1;
      end
      HALT: halted_o = 1'b1;
      default: ;
    endcase
  end

  assign bus.PCout       = drv.pc;
  assign bus.MDRout      = drv.mdr;
  assign bus.Zlowout     = drv.zlow;
  assign bus.Zhighout    = drv.zhigh;
  assign bus.HIout       = drv.hi;
  assign bus.LOout       = drv.lo;
  assign bus.Yout        = drv.y;
  assign bus.InPortout   = drv.inport;
  assign bus.Cout        = drv.c;
  assign bus.RoutSignals = rout;

  assign bus.MARin       = ld.mar;
  assign bus.PCin        = ld.pc;
  assign bus.MDRin       = ld.mdr;
  assign bus.IRin        = ld.ir;
  assign bus.Yin         = ld.y;
  assign bus.Zin         = ld.z;
  assign bus.IncPC       = ld.inc_pc;
  assign bus.Read        = ld.read;
  assign bus.Rin         = rin;

  assign bus.alu_op      = alu;
  assign bus.done        = done_o;
  assign bus.halted      = halted_o;

endmodule

// File: tb/tb_bus_drive_sequencer.sv
// Bench for bus_drive_sequencer: directed table, hand sequences for reset/halt/
// run-drop corners, and random instructions against an instruction-level model.
module tb_bus_drive_sequencer;

  logic clock, reset_n;
  bus_drive_sequencer_if bus ();

  bus_drive_sequencer dut (.clock(clock), .reset_n(reset_n), .bus(bus));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct packed {
    logic PCout, MDRout, Zlowout, Zhighout, HIout, LOout, Yout, InPortout, Cout;
    logic [15:0] rout;
    logic MARin, PCin, MDRin, IRin, Yin, Zin, IncPC, Read;
    logic [15:0] rin;
    logic [4:0]  alu_op;
    logic done, halted;
  } out_t;

  typedef struct {
    out_t exp;
    logic mr;
  } step_t;

  typedef struct {
    logic [31:0] ir;
    int          waits;
    int          exp_lat;
    logic [15:0] exp_rin;
  } dir_t;

  int vectors = 0;
  int miscompares = 0;

  function automatic logic [31:0] enc(input logic [4:0] op, input logic [3:0] a, b, c);
    enc = {op, a, b, c, 15'b0};
  endfunction

  function automatic out_t sample();
    out_t a;
    a.PCout = bus.PCout;   a.MDRout = bus.MDRout; a.Zlowout = bus.Zlowout;
    a.Zhighout = bus.Zhighout; a.HIout = bus.HIout; a.LOout = bus.LOout;
    a.Yout = bus.Yout;     a.InPortout = bus.InPortout; a.Cout = bus.Cout;
    a.rout = bus.RoutSignals;
    a.MARin = bus.MARin;   a.PCin = bus.PCin;     a.MDRin = bus.MDRin;
    a.IRin = bus.IRin;     a.Yin = bus.Yin;       a.Zin = bus.Zin;
    a.IncPC = bus.IncPC;   a.Read = bus.Read;
    a.rin = bus.Rin;       a.alu_op = bus.alu_op;
    a.done = bus.done;     a.halted = bus.halted;
    return a;
  endfunction

  task automatic chk(input string name, input out_t exp);
    out_t act;
    act = sample();
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: outputs got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // From IDLE at a falling edge: request a fetch; returns at the falling edge inside T0.
  task automatic start();
    bus.run = 1'b1;
    @(negedge clock);
  endtask

  // Instruction-level model: lists the expected output of every step of one
  // instruction from its opcode and memory wait count, then plays it against
  // the DUT. Entered and left at a falling edge; entry is inside T0.
  task automatic exec_instr(input logic [31:0] ir, input int waits, input logic run_after,
                            input bit noise, input int drop_from, input string tag);
    step_t q[$];
    step_t s;
    logic [4:0] op;
    logic [3:0] a, b, c;
    op = ir[31:27]; a = ir[26:23]; b = ir[22:19]; c = ir[18:15];
    bus.ir = ir;
    s.exp = '0; s.exp.PCout = 1; s.exp.MARin = 1; s.exp.IncPC = 1; s.exp.Zin = 1;
    s.mr = 1'($urandom_range(1)); q.push_back(s);
    for (int k = 0; k <= waits; k++) begin
      s.exp = '0; s.exp.Zlowout = 1; s.exp.Read = 1; s.exp.MDRin = 1; s.exp.PCin = (k == 0);
      s.mr = (k == waits); q.push_back(s);
    end
    s.exp = '0; s.exp.MDRout = 1; s.exp.IRin = 1;
    s.mr = 1'($urandom_range(1)); q.push_back(s);
    if (op < 5'd4) begin
      s.exp = '0; s.exp.rout = 16'd1 << b; s.exp.Yin = 1; q.push_back(s);
      s.exp = '0; s.exp.rout = 16'd1 << c; s.exp.Zin = 1; s.exp.alu_op = op; q.push_back(s);
      s.exp = '0; s.exp.Zlowout = 1; s.exp.rin = 16'd1 << a; s.exp.done = 1; q.push_back(s);
    end else if (op == 5'd24) begin
      s.exp = '0; s.exp.HIout = 1; s.exp.rin = 16'd1 << a; s.exp.done = 1; q.push_back(s);
    end else if (op == 5'd25) begin
      s.exp = '0; s.exp.LOout = 1; s.exp.rin = 16'd1 << a; s.exp.done = 1; q.push_back(s);
    end else begin
      s.exp = '0; s.exp.done = 1; q.push_back(s);
    end
    foreach (q[i]) begin
      chk($sformatf("%s[%0d]", tag, i), q[i].exp);
      bus.mem_ready = q[i].mr;
      if (i == q.size() - 1)              bus.run = run_after;
      else if (noise)                     bus.run = 1'($urandom_range(1));
      else if (drop_from >= 0 && i >= drop_from) bus.run = 1'b0;
      else                                bus.run = 1'b1;
      @(negedge clock);
    end
  endtask

  // Directed entry: measure latency, Rin at done, Read and PCin cycle counts.
  task automatic do_dir(input dir_t d, input int idx);
    int n, reads, pcins;
    bit fin;
    logic [15:0] got_rin;
    n = 0; reads = 0; pcins = 0; fin = 0; got_rin = '0;
    bus.ir = d.ir;
    while (n < 40 && !fin) begin
      n++;
      if (bus.Read) begin
        reads++;
        bus.mem_ready = (reads > d.waits);
      end else begin
        bus.mem_ready = 1'b0;
      end
      if (bus.PCin) pcins++;
      if (bus.done) begin
        fin = 1; got_rin = bus.Rin; bus.run = 1'b0;
      end else begin
        bus.run = 1'b1;
      end
      @(negedge clock);
    end
    chk_int($sformatf("dir%0d_latency", idx), fin ? n : -1, d.exp_lat);
    chk_int($sformatf("dir%0d_rin", idx), int'(got_rin), int'(d.exp_rin));
    chk_int($sformatf("dir%0d_read_cycles", idx), reads, d.waits + 1);
    chk_int($sformatf("dir%0d_pcin_cycles", idx), pcins, 1);
    chk($sformatf("dir%0d_idle", idx), '0);
    start();
  endtask

  // At most one bus driver in every cycle.
  always @(negedge clock) begin
    assert ($countones({bus.PCout, bus.MDRout, bus.Zlowout, bus.Zhighout, bus.HIout,
                        bus.LOout, bus.Yout, bus.InPortout, bus.Cout, bus.RoutSignals}) <= 1)
      else $error("FAIL bus_drive_onehot: more than one driver, got RoutSignals=%h", bus.RoutSignals);
  end

  initial begin
    dir_t tbl[7];
    out_t hz;
    logic [31:0] rnd;
    logic [4:0]  op;
    int          waits;
    logic        ra;

    tbl[0] = '{enc(5'd0, 4'd3, 4'd1, 4'd2),   0, 6, 16'h0008};  // add R3,R1,R2
    tbl[1] = '{enc(5'd0, 4'd3, 4'd1, 4'd2),   3, 9, 16'h0008};  // with 3 wait cycles
    tbl[2] = '{32'hC280_0000,                 0, 4, 16'h0020};  // mfhi R5
    tbl[3] = '{enc(5'd25, 4'd15, 4'd0, 4'd0), 0, 4, 16'h8000};  // mflo R15
    tbl[4] = '{enc(5'd1, 4'd7, 4'd7, 4'd7),   0, 6, 16'h0080};  // sub R7,R7,R7
    tbl[5] = '{enc(5'd5, 4'd9, 4'd1, 4'd1),   2, 6, 16'h0000};  // unknown opcode
    tbl[6] = '{enc(5'd3, 4'd0, 4'd15, 4'd8),  1, 7, 16'h0001};  // or R0

    reset_n = 1'b0; bus.run = 1'b0; bus.mem_ready = 1'b0; bus.ir = '0;
    @(negedge clock); @(negedge clock);
    chk("reset", '0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("idle_run0", '0);
    start();

    foreach (tbl[i]) do_dir(tbl[i], i);

    // run falls during T4: instruction still completes, then IDLE
    exec_instr(enc(5'd0, 4'd4, 4'd2, 4'd9), 1, 1'b0, 0, 5, "drop");
    chk("drop_idle0", '0);
    @(negedge clock);
    chk("drop_idle1", '0);
    start();

    // asynchronous reset while waiting in T1
    bus.ir = enc(5'd0, 4'd3, 4'd1, 4'd2);
    bus.mem_ready = 1'b0;
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1 chk("reset_mid_t1", '0);
    @(negedge clock);
    reset_n = 1'b1; bus.run = 1'b1;
    chk("reset_mid_t1_idle", '0);
    @(negedge clock);
    exec_instr(enc(5'd0, 4'd3, 4'd1, 4'd2), 0, 1'b1, 0, -1, "after_reset");

    // random instruction stream
    for (int n = 0; n < 40; n++) begin
      rnd = $urandom();
      case ($urandom_range(7))
        0, 1, 2, 3: op = 5'($urandom_range(3));
        4:          op = 5'd24;
        5:          op = 5'd25;
        6:          op = 5'($urandom_range(23, 4));
        default:    op = 5'($urandom_range(31, 27));
      endcase
      rnd[31:27] = op;
      waits = $urandom_range(3);
      ra = ($urandom_range(3) != 0);
      exec_instr(rnd, waits, ra, 1, -1, $sformatf("rnd%0d", n));
      if (!ra) begin
        chk($sformatf("rnd%0d_idle", n), '0);
        start();
      end
    end

    // halt: done at step 4, then parked until reset
    rnd = $urandom();
    rnd[31:27] = 5'b11010;
    exec_instr(rnd, 0, 1'b1, 1, -1, "halt");
    hz = '0; hz.halted = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("halted%0d", k), hz);
      bus.run = 1'($urandom_range(1)); bus.mem_ready = 1'($urandom_range(1));
      @(negedge clock);
    end
    #2 reset_n = 1'b0;
    #1 chk("halt_reset", '0);
    @(negedge clock);
    reset_n = 1'b1; bus.run = 1'b0;
    chk("halt_reset_idle0", '0);
    @(negedge clock);
    chk("halt_reset_idle1", '0);
    start();
    exec_instr(enc(5'd2, 4'd6, 4'd11, 4'd12), 2, 1'b0, 0, -1, "post_halt");
    chk("final_idle", '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
